frame_sequencer: RTL and testbench

- Parametrised successor to the game control FSM. Sequences one video frame per game tick: clear → ship → N enemies → bullets → update.
- Each draw phase uses a start/done handshake with the draw datapath instead of advancing on the tick alone.
- Owns the ship and enemy x positions: ship moves under user control, enemies bounce between bounds.
- Sits between the top level (board clk, reset, keys) and the VGA draw datapath / grid logic.

---
 rtl/game_pkg.sv | 28 ++
 rtl/frame_sequencer_if.sv | 24 ++
 rtl/tick_divider.sv | 27 ++
 rtl/frame_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_frame_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game frame sequencer: FSM states, draw job
// encodings and a small width helper.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIP,
    S_ENEMY,
    S_BULLETS,
    S_UPDATE,
    S_WAIT
  } state_t;

  typedef logic [2:0] draw_sel_t;

  localparam draw_sel_t DRAW_CLEAR   = 3'd0;
  localparam draw_sel_t DRAW_SHIP    = 3'd1;
  localparam draw_sel_t DRAW_ENEMY   = 3'd2;
  localparam draw_sel_t DRAW_BULLETS = 3'd3;
  localparam draw_sel_t DRAW_NONE    = 3'd7;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Draw handshake between the frame sequencer (master) and the VGA draw
// datapath (slave).
interface frame_sequencer_if #(
  parameter int IDX_W = 2
);
  import game_pkg::*;

  logic             draw_start;
  draw_sel_t        draw_sel;
  logic [IDX_W-1:0] enemy_idx;
  logic             write_en;
  logic             draw_done;

  modport master (
    output draw_start, draw_sel, enemy_idx, write_en,
    input  draw_done
  );

  modport slave (
    input  draw_start, draw_sel, enemy_idx, write_en,
    output draw_done
  );

endinterface

// File: rtl/tick_divider.sv
// Free-running down-counter producing a one-cycle game tick every TICK_DIV
// clocks; the first tick lands TICK_DIV cycles after reset release.
module tick_divider
  import game_pkg::*;
#(
  parameter  int TICK_DIV = 3125000,
  localparam int CNT_W    = cnt_width(TICK_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

  assign tick = (count == '0);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= RELOAD;
    else if (tick) count <= RELOAD;
    else           count <= count - 1'b1;
  end

endmodule

// File: rtl/frame_sequencer.sv
// Per-tick frame sequencer: clear -> ship -> enemies -> bullets -> update,
// each draw job launched by a start pulse and retired by draw_done.
module frame_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV      = 3125000,
  parameter int NUM_ENEMIES   = 4,
  parameter int IDX_W         = 2,
  parameter int X_W           = 8,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 152,
  parameter int X_START       = 80,
  parameter int SHIP_STEP     = 4,
  parameter int ENEMY_STEP    = 2,
  parameter int ENEMY_SPACING = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pause,
  input  logic                       move_left,
  input  logic                       move_right,
  frame_sequencer_if.master          draw,
  output logic                       ship_update_en,
  output logic                       grid_update_en,
  output logic [X_W-1:0]             user_x,
  output logic [NUM_ENEMIES*X_W-1:0] enemy_x,
  output logic                       frame_overrun,
  output logic [15:0]                frame_count
);

  localparam int               CNT_W        = cnt_width(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_MAX     = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_ENEMIES - 1);
  localparam logic [X_W-1:0]   XMIN_V       = X_W'(X_MIN);
  localparam logic [X_W-1:0]   XMAX_V       = X_W'(X_MAX);
  localparam logic [X_W-1:0]   SHIP_STEP_V  = X_W'(SHIP_STEP);
  localparam logic [X_W-1:0]   SHIP_LO      = X_W'(X_MIN + SHIP_STEP);
  localparam logic [X_W-1:0]   SHIP_HI      = X_W'(X_MAX - SHIP_STEP);
  localparam logic [X_W-1:0]   ENEMY_STEP_V = X_W'(ENEMY_STEP);
  localparam logic [X_W-1:0]   ENEMY_LO     = X_W'(X_MIN + ENEMY_STEP);
  localparam logic [X_W-1:0]   ENEMY_HI     = X_W'(X_MAX - ENEMY_STEP);

  state_t           state, state_nxt;
  logic             launch, launch_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             tick, done_acc, busy, in_frame;
  logic [CNT_W-1:0] tick_count;
  draw_sel_t        sel;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .count (tick_count)
  );

  // launch is high only in the first cycle of a draw job, so a done still
  // asserted from the previous job is never taken as completion of this one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case statement can infer a latch.
    state_nxt  = state;
    launch_nxt = 1'b0;
    idx_nxt    = idx;
    sel        = DRAW_NONE;
    busy       = 1'b0;
    done_acc   = draw.draw_done && !launch;
    case (state)
      S_IDLE: if (tick) begin
        state_nxt  = S_CLEAR;
        launch_nxt = 1'b1;
      end
      S_CLEAR: begin
        sel  = DRAW_CLEAR;
        busy = 1'b1;
        if (done_acc) begin
          state_nxt  = S_SHIP;
          launch_nxt = 1'b1;
        end
      end
      S_SHIP: begin
        sel  = DRAW_SHIP;
        busy = 1'b1;
        if (done_acc) begin
          state_nxt  = S_ENEMY;
          idx_nxt    = '0;
          launch_nxt = 1'b1;
        end
      end
      S_ENEMY: begin
        sel  = DRAW_ENEMY;
        busy = 1'b1;
        if (done_acc) begin
          launch_nxt = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = S_BULLETS;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      S_BULLETS: begin
        sel  = DRAW_BULLETS;
        busy = 1'b1;
        if (done_acc) state_nxt = S_UPDATE;
      end
      S_UPDATE: state_nxt = S_WAIT;
      S_WAIT: if (tick && !pause) begin
        state_nxt  = S_CLEAR;
        launch_nxt = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign in_frame = (state != S_IDLE) && (state != S_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      launch        <= 1'b0;
      idx           <= '0;
      frame_overrun <= 1'b0;
      frame_count   <= '0;
    end else begin
      state  <= state_nxt;
      launch <= launch_nxt;
      idx    <= idx_nxt;
      if (tick && in_frame)   frame_overrun <= 1'b1;
      if (state == S_UPDATE)  frame_count   <= frame_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      user_x <= X_W'(X_START);
    end else if (state == S_UPDATE) begin
      if (move_left && !move_right)
        user_x <= (user_x >= SHIP_LO) ? user_x - SHIP_STEP_V : XMIN_V;
      else if (move_right && !move_left)
        user_x <= (user_x <= SHIP_HI) ? user_x + SHIP_STEP_V : XMAX_V;
    end
  end

  // Reaching or passing a bound parks the enemy on it and turns it around.
  for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_enemy
    localparam logic [X_W-1:0] X_INIT = X_W'(X_MIN + i * ENEMY_SPACING);
    logic [X_W-1:0] x;
    logic           dir_right;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        x         <= X_INIT;
        dir_right <= 1'b1;
      end else if (state == S_UPDATE) begin
        if (dir_right) begin
          if (x >= ENEMY_HI) begin
            x         <= XMAX_V;
            dir_right <= 1'b0;
          end else begin
            x <= x + ENEMY_STEP_V;
          end
        end else begin
          if (x <= ENEMY_LO) begin
            x         <= XMIN_V;
            dir_right <= 1'b1;
          end else begin
            x <= x - ENEMY_STEP_V;
          end
        end
      end
    end

    assign enemy_x[i*X_W +: X_W] = x;
  end

  assign draw.draw_start = launch;
  assign draw.draw_sel   = sel;
  assign draw.enemy_idx  = idx;
  assign draw.write_en   = busy;
  assign ship_update_en  = (state == S_UPDATE);
  assign grid_update_en  = (state == S_UPDATE);

  assert property (@(posedge clk) disable iff (reset) tick_count <= TICK_MAX);

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: job ordering, tick timing, ship and
// enemy movement, pause, overrun and mid-frame reset.
module tb_frame_sequencer;
  import game_pkg::*;

  localparam int TICK_DIV = 16;
  localparam int NE       = 2;
  localparam int IDX_W    = 1;
  localparam int X_W      = 8;

  logic clk = 1'b0, reset = 1'b1, pause = 1'b0, move_left = 1'b0, move_right = 1'b0;
  logic ship_update_en, grid_update_en, frame_overrun;
  logic [X_W-1:0]    user_x;
  logic [NE*X_W-1:0] enemy_x;
  logic [15:0]       frame_count;

  frame_sequencer_if #(.IDX_W(IDX_W)) dif ();

  frame_sequencer #(
    .TICK_DIV(TICK_DIV), .NUM_ENEMIES(NE), .IDX_W(IDX_W), .X_W(X_W),
    .X_MIN(0), .X_MAX(152), .X_START(80), .SHIP_STEP(4), .ENEMY_STEP(2),
    .ENEMY_SPACING(32)
  ) dut (
    .clk(clk), .reset(reset), .pause(pause), .move_left(move_left),
    .move_right(move_right), .draw(dif), .ship_update_en(ship_update_en),
    .grid_update_en(grid_update_en), .user_x(user_x), .enemy_x(enemy_x),
    .frame_overrun(frame_overrun), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;

  // Per-frame observations filled by run_frame.
  int               pulses, start_wait, first_cyc;
  logic             timed_out, upd_ok, upd_after;
  logic [2:0]       sel_log [8];
  logic [IDX_W-1:0] idx_log [8];

  // Expected enemy positions, stepped once per completed frame.
  int m_x   [NE];
  bit m_dir [NE];

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_x[i]   = i * 32;
      m_dir[i] = 1'b1;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NE; i++) begin
      if (m_dir[i]) begin
        if (m_x[i] + 2 >= 152) begin m_x[i] = 152; m_dir[i] = 1'b0; end
        else m_x[i] = m_x[i] + 2;
      end else begin
        if (m_x[i] - 2 <= 0) begin m_x[i] = 0; m_dir[i] = 1'b1; end
        else m_x[i] = m_x[i] - 2;
      end
    end
  endtask

  function automatic logic [NE*X_W-1:0] model_packed();
    logic [NE*X_W-1:0] v;
    for (int i = 0; i < NE; i++) v[i*X_W +: X_W] = X_W'(m_x[i]);
    return v;
  endfunction

  // Waits for the next draw_start, logs every pulse up to the update cycle,
  // then steps one cycle further so updated positions are visible.
  task automatic run_frame();
    int n;
    pulses = 0; timed_out = 1'b0; upd_ok = 1'b0; upd_after = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!dif.draw_start && n < 200);
    start_wait = n;
    first_cyc  = cyc;
    if (!dif.draw_start) timed_out = 1'b1;
    n = 0;
    while (!timed_out && !ship_update_en) begin
      if (dif.draw_start) begin
        if (pulses < 8) begin
          sel_log[pulses] = dif.draw_sel;
          idx_log[pulses] = dif.enemy_idx;
        end
        pulses++;
      end
      @(negedge clk);
      n++;
      if (n > 200) timed_out = 1'b1;
    end
    if (!timed_out) begin
      upd_ok = ship_update_en && grid_update_en;
      @(negedge clk);
      upd_after = ship_update_en || grid_update_en;
      model_step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (dif.draw_start !== 1'b0) begin miscompares++; $display("FAIL reset_draw_start: got %b want 0", dif.draw_start); end
    vectors++; if (dif.draw_sel !== DRAW_NONE) begin miscompares++; $display("FAIL reset_draw_sel: got %0d want 7", dif.draw_sel); end
    vectors++; if (dif.enemy_idx !== '0) begin miscompares++; $display("FAIL reset_enemy_idx: got %0d want 0", dif.enemy_idx); end
    vectors++; if (dif.write_en !== 1'b0) begin miscompares++; $display("FAIL reset_write_en: got %b want 0", dif.write_en); end
    vectors++; if ({ship_update_en, grid_update_en} !== 2'b00) begin miscompares++; $display("FAIL reset_update_en: got %b want 00", {ship_update_en, grid_update_en}); end
    vectors++; if (user_x !== 8'd80) begin miscompares++; $display("FAIL reset_user_x: got %0d want 80", user_x); end
    vectors++; if (enemy_x !== 16'h2000) begin miscompares++; $display("FAIL reset_enemy_x: got %h want 2000", enemy_x); end
    vectors++; if (frame_overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", frame_overrun); end
    vectors++; if (frame_count !== 16'd0) begin miscompares++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_first_frame();
    run_frame();
    vectors++; if (timed_out) begin miscompares++; $display("FAIL first_frame_timeout: got timeout want frame"); end
    vectors++; if (start_wait !== 16) begin miscompares++; $display("FAIL first_start_cycle: got %0d want 16", start_wait); end
    vectors++; if (pulses !== 5) begin miscompares++; $display("FAIL first_pulse_count: got %0d want 5", pulses); end
    vectors++; if ({sel_log[0], sel_log[1], sel_log[2], sel_log[3], sel_log[4]} !== {3'd0, 3'd1, 3'd2, 3'd2, 3'd3})
      begin miscompares++; $display("FAIL first_sel_order: got %0d %0d %0d %0d %0d want 0 1 2 2 3", sel_log[0], sel_log[1], sel_log[2], sel_log[3], sel_log[4]); end
    vectors++; if ({idx_log[2], idx_log[3]} !== 2'b01) begin miscompares++; $display("FAIL first_enemy_idx: got %0d %0d want 0 1", idx_log[2], idx_log[3]); end
    vectors++; if ({upd_ok, upd_after} !== 2'b10) begin miscompares++; $display("FAIL first_update_strobe: got %b want 10", {upd_ok, upd_after}); end
    vectors++; if (frame_count !== 16'd1) begin miscompares++; $display("FAIL first_frame_count: got %0d want 1", frame_count); end
    vectors++; if (frame_overrun !== 1'b0) begin miscompares++; $display("FAIL first_overrun: got %b want 0", frame_overrun); end
    vectors++; if (user_x !== 8'd80) begin miscompares++; $display("FAIL first_user_x: got %0d want 80", user_x); end
    vectors++; if (enemy_x !== 16'h2202) begin miscompares++; $display("FAIL first_enemy_x: got %h want 2202", enemy_x); end
  endtask

  task automatic test_ship_move();
    int exp_x;
    move_right = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      run_frame();
      exp_x = (80 + 4 * k > 152) ? 152 : 80 + 4 * k;
      vectors++; if (user_x !== X_W'(exp_x)) begin miscompares++; $display("FAIL ship_right_%0d: got %0d want %0d", k, user_x, exp_x); end
      vectors++; if (enemy_x !== model_packed()) begin miscompares++; $display("FAIL enemy_right_%0d: got %h want %h", k, enemy_x, model_packed()); end
    end
    move_left = 1'b1;
    run_frame();
    vectors++; if (user_x !== 8'd152) begin miscompares++; $display("FAIL ship_both: got %0d want 152", user_x); end
    move_right = 1'b0;
    for (int k = 1; k <= 38; k++) begin
      run_frame();
      exp_x = (152 - 4 * k < 0) ? 0 : 152 - 4 * k;
      vectors++; if (user_x !== X_W'(exp_x)) begin miscompares++; $display("FAIL ship_left_%0d: got %0d want %0d", k, user_x, exp_x); end
      vectors++; if (enemy_x !== model_packed()) begin miscompares++; $display("FAIL enemy_left_%0d: got %h want %h", k, enemy_x, model_packed()); end
    end
    // Frame 60: enemy 1 lands on X_MAX and turns; enemy 0 at 120.
    vectors++; if (enemy_x !== 16'h9878) begin miscompares++; $display("FAIL enemy_at_bound: got %h want 9878", enemy_x); end
    move_left = 1'b0;
  endtask

  task automatic test_pause();
    logic seen;
    seen  = 1'b0;
    pause = 1'b1;
    repeat (3 * TICK_DIV + 4) begin
      @(negedge clk);
      if (dif.draw_start || dif.write_en) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL pause_draw: got activity want none"); end
    vectors++; if (frame_count !== 16'd60) begin miscompares++; $display("FAIL pause_frame_count: got %0d want 60", frame_count); end
    vectors++; if (frame_overrun !== 1'b0) begin miscompares++; $display("FAIL pause_overrun: got %b want 0", frame_overrun); end
    pause = 1'b0;
    run_frame();
    vectors++; if (timed_out || start_wait > TICK_DIV) begin miscompares++; $display("FAIL pause_resume_wait: got %0d want <=16", start_wait); end
    vectors++; if (sel_log[0] !== DRAW_CLEAR) begin miscompares++; $display("FAIL pause_resume_sel: got %0d want 0", sel_log[0]); end
    vectors++; if (frame_count !== 16'd61) begin miscompares++; $display("FAIL pause_resume_count: got %0d want 61", frame_count); end
    vectors++; if (enemy_x !== 16'h967A) begin miscompares++; $display("FAIL enemy_turned: got %h want 967a", enemy_x); end
  endtask

  task automatic test_overrun();
    int n, c0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(dif.draw_start && dif.draw_sel == DRAW_CLEAR) && n < 100);
    c0 = cyc;
    do begin @(negedge clk); n++; end while (!(dif.draw_start && dif.draw_sel == DRAW_SHIP) && n < 100);
    vectors++; if (n >= 100) begin miscompares++; $display("FAIL overrun_ship_wait: got timeout want ship pulse"); end
    dif.draw_done = 1'b0;
    repeat (20) @(negedge clk);
    vectors++; if (dif.draw_sel !== DRAW_SHIP) begin miscompares++; $display("FAIL overrun_hold_sel: got %0d want 1", dif.draw_sel); end
    vectors++; if (frame_overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set: got %b want 1", frame_overrun); end
    dif.draw_done = 1'b1;
    run_frame();
    vectors++; if (timed_out || pulses !== 3) begin miscompares++; $display("FAIL overrun_finish_pulses: got %0d want 3", pulses); end
    vectors++; if (frame_count !== 16'd62) begin miscompares++; $display("FAIL overrun_frame_count: got %0d want 62", frame_count); end
    run_frame();
    vectors++; if (first_cyc - c0 !== 2 * TICK_DIV) begin miscompares++; $display("FAIL overrun_next_clear: got %0d want %0d", first_cyc - c0, 2 * TICK_DIV); end
    vectors++; if (frame_overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_sticky: got %b want 1", frame_overrun); end
    vectors++; if (frame_count !== 16'd63) begin miscompares++; $display("FAIL overrun_next_count: got %0d want 63", frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(dif.draw_start && dif.draw_sel == DRAW_ENEMY && dif.enemy_idx == 1'b1) && n < 100);
    vectors++; if (n >= 100) begin miscompares++; $display("FAIL midreset_wait: got timeout want enemy 1"); end
    reset = 1'b1;
    #1;
    vectors++; if (dif.write_en !== 1'b0) begin miscompares++; $display("FAIL midreset_write_en: got %b want 0", dif.write_en); end
    vectors++; if (dif.draw_start !== 1'b0) begin miscompares++; $display("FAIL midreset_draw_start: got %b want 0", dif.draw_start); end
    vectors++; if (dif.enemy_idx !== '0) begin miscompares++; $display("FAIL midreset_enemy_idx: got %0d want 0", dif.enemy_idx); end
    vectors++; if (dif.draw_sel !== DRAW_NONE) begin miscompares++; $display("FAIL midreset_draw_sel: got %0d want 7", dif.draw_sel); end
    vectors++; if (user_x !== 8'd80) begin miscompares++; $display("FAIL midreset_user_x: got %0d want 80", user_x); end
    vectors++; if (frame_count !== 16'd0) begin miscompares++; $display("FAIL midreset_frame_count: got %0d want 0", frame_count); end
    vectors++; if (frame_overrun !== 1'b0) begin miscompares++; $display("FAIL midreset_overrun: got %b want 0", frame_overrun); end
    vectors++; if (enemy_x !== 16'h2000) begin miscompares++; $display("FAIL midreset_enemy_x: got %h want 2000", enemy_x); end
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b0;
    run_frame();
    vectors++; if (timed_out || start_wait !== 16) begin miscompares++; $display("FAIL midreset_first_start: got %0d want 16", start_wait); end
    vectors++; if (frame_count !== 16'd1) begin miscompares++; $display("FAIL midreset_frame_count_after: got %0d want 1", frame_count); end
    vectors++; if (enemy_x !== 16'h2202) begin miscompares++; $display("FAIL midreset_enemy_after: got %h want 2202", enemy_x); end
  endtask

  initial begin
    dif.draw_done = 1'b1;
    test_reset();
    test_first_frame();
    test_ship_move();
    test_pause();
    test_overrun();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
